// File: rtl/bus_pkg.sv
// Shared encodings for the 68000 bus-cycle controller: decoded regions, FSM states
// and the interrupt-acknowledge function code.
package bus_pkg;

   typedef enum logic [2:0] {
      REG_ROM  = 3'd0,
      REG_RAM  = 3'd1,
      REG_IO   = 3'd2,
      REG_CTRL = 3'd3,
      REG_NONE = 3'd4
   } region_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [2:0] FC_IACK = 3'b111;

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address/function-code decode: picks the target region and flags
// accesses that must terminate with a bus error.
module bus_region_decode
   import bus_pkg::*;
(
   input  logic [3:0] addr_hi,
   input  logic [2:0] fc,
   input  logic       write,
   output region_t    region,
   output logic       fault
);

   always_comb begin
      region = REG_NONE;
      case (addr_hi)
         4'h0:                                   region = REG_ROM;
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: region = REG_RAM;
         4'hE:                                   region = REG_IO;
         4'hF:                                   region = REG_CTRL;
         default:                                region = REG_NONE;
      endcase
   end

   // Interrupt acknowledge is never serviced here; autovectoring lives elsewhere.
   always_comb begin
      fault = (region == REG_NONE)
            | ((region == REG_CTRL) & ~fc[2])
            | ((region == REG_ROM) & write)
            | (fc == FC_IACK);
   end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle sequencer: selects one target, inserts wait states or waits on
// io_ready, and terminates each cycle with DTACK or BERR.
module bus_cycle_ctrl
   import bus_pkg::*;
#(
   parameter int ROM_WS     = 2,
   parameter int RAM_WS     = 0,
   parameter int CTRL_WS    = 1,
   parameter int IO_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       as,
   input  logic       write,
   input  logic       lds,
   input  logic       uds,
   input  logic [2:0] fc,
   input  logic [3:0] addr_hi,
   input  logic       io_ready,
   output logic       rom_en,
   output logic       ram_en,
   output logic       ctrl_en,
   output logic       io_en,
   output logic       dtack,
   output logic       berr,
   output logic       busy
);

   region_t    dec_region;
   logic       dec_fault;

   state_t     state_q, state_d;
   region_t    region_q, region_d;
   logic [7:0] cnt_q, cnt_d;

   logic rom_en_q, ram_en_q, ctrl_en_q, io_en_q, dtack_q, berr_q, busy_q;
   logic rom_en_d, ram_en_d, ctrl_en_d, io_en_d, dtack_d, berr_d, busy_d;
   logic en_active;

   bus_region_decode u_decode (
      .addr_hi (addr_hi),
      .fc      (fc),
      .write   (write),
      .region  (dec_region),
      .fault   (dec_fault)
   );

   function automatic logic [7:0] wait_states(input region_t r);
      case (r)
         REG_ROM:  return 8'(ROM_WS);
         REG_RAM:  return 8'(RAM_WS);
         REG_CTRL: return 8'(CTRL_WS);
         default:  return 8'd0;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      region_d = region_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            // Region is frozen here; later address changes are ignored.
            if (as && (lds || uds)) begin
               region_d = dec_region;
               cnt_d    = wait_states(dec_region);
               state_d  = dec_fault ? S_ERR : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!as) begin
               state_d = S_IDLE;
            end else if (region_q == REG_IO) begin
               // IO counts up towards the timeout; io_ready wins a tie.
               if (io_ready)                             state_d = S_ACK;
               else if (cnt_q == 8'(IO_TIMEOUT - 1))     state_d = S_ERR;
               else                                      cnt_d   = cnt_q + 8'd1;
            end else if (cnt_q == 8'd0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_ACK, S_ERR: begin
            if (!as) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered one edge behind the state they reflect.
   always_comb begin
      en_active = (state_q == S_WAIT) || (state_q == S_ACK);
      rom_en_d  = en_active && (region_q == REG_ROM);
      ram_en_d  = en_active && (region_q == REG_RAM);
      ctrl_en_d = en_active && (region_q == REG_CTRL);
      io_en_d   = en_active && (region_q == REG_IO);
      dtack_d   = (state_q == S_ACK);
      berr_d    = (state_q == S_ERR);
      busy_d    = (state_q != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         region_q  <= REG_NONE;
         cnt_q     <= 8'd0;
         rom_en_q  <= 1'b0;
         ram_en_q  <= 1'b0;
         ctrl_en_q <= 1'b0;
         io_en_q   <= 1'b0;
         dtack_q   <= 1'b0;
         berr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         region_q  <= region_d;
         cnt_q     <= cnt_d;
         rom_en_q  <= rom_en_d;
         ram_en_q  <= ram_en_d;
         ctrl_en_q <= ctrl_en_d;
         io_en_q   <= io_en_d;
         dtack_q   <= dtack_d;
         berr_q    <= berr_d;
         busy_q    <= busy_d;
      end
   end

   assign rom_en  = rom_en_q;
   assign ram_en  = ram_en_q;
   assign ctrl_en = ctrl_en_q;
   assign io_en   = io_en_q;
   assign dtack   = dtack_q;
   assign berr    = berr_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl; outputs packed as {rom,ram,ctrl,io,dtack,berr,busy}.
module tb_bus_cycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       as = 1'b0, write = 1'b0, lds = 1'b0, uds = 1'b0, io_ready = 1'b0;
   logic [2:0] fc = 3'b000;
   logic [3:0] addr_hi = 4'h0;

   logic rom_en, ram_en, ctrl_en, io_en, dtack, berr, busy;
   logic rom_en3, ram_en3, ctrl_en3, io_en3, dtack3, berr3, busy3;
   logic [6:0] o, o3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bus_cycle_ctrl #(.ROM_WS(2), .RAM_WS(0), .CTRL_WS(1), .IO_TIMEOUT(64)) u_dut (
      .clk(clk), .rst_n(rst_n), .as(as), .write(write), .lds(lds), .uds(uds),
      .fc(fc), .addr_hi(addr_hi), .io_ready(io_ready),
      .rom_en(rom_en), .ram_en(ram_en), .ctrl_en(ctrl_en), .io_en(io_en),
      .dtack(dtack), .berr(berr), .busy(busy)
   );

   bus_cycle_ctrl #(.ROM_WS(2), .RAM_WS(3), .CTRL_WS(1), .IO_TIMEOUT(64)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .as(as), .write(write), .lds(lds), .uds(uds),
      .fc(fc), .addr_hi(addr_hi), .io_ready(io_ready),
      .rom_en(rom_en3), .ram_en(ram_en3), .ctrl_en(ctrl_en3), .io_en(io_en3),
      .dtack(dtack3), .berr(berr3), .busy(busy3)
   );

   assign o  = {rom_en,  ram_en,  ctrl_en,  io_en,  dtack,  berr,  busy};
   assign o3 = {rom_en3, ram_en3, ctrl_en3, io_en3, dtack3, berr3, busy3};

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start(input logic [3:0] a, input logic [2:0] f, input logic w);
      addr_hi = a; fc = f; write = w; as = 1'b1; lds = 1'b1; uds = 1'b0;
   endtask

   task automatic release_bus();
      as = 1'b0; lds = 1'b0; uds = 1'b0; write = 1'b0; io_ready = 1'b0;
   endtask

   initial begin
      // reset
      step(2);
      chk("reset_outputs", o, 7'b0000000);
      rst_n = 1'b1;
      step(1);
      chk("post_reset_idle", o, 7'b0000000);

      // RAM read, 0 wait states
      start(4'h2, 3'b101, 1'b0);
      step(1); chk("ram_e0", o, 7'b0000000);
      step(1); chk("ram_e1_en", o, 7'b0100001);
      step(1); chk("ram_e2_dtack", o, 7'b0100101);
      step(2); chk("ram_e4_hold", o, 7'b0100101);
      release_bus();
      step(1); chk("ram_e5", o, 7'b0100101);
      step(1); chk("ram_e6_clear", o, 7'b0000000);

      // ROM read, 2 wait states
      start(4'h0, 3'b110, 1'b0);
      step(2); chk("rom_e1_en", o, 7'b1000001);
      step(2); chk("rom_e3_nodtack", o, 7'b1000001);
      step(1); chk("rom_e4_dtack", o, 7'b1000101);
      release_bus(); step(2);
      chk("rom_idle", o, 7'b0000000);

      // ROM write faults
      start(4'h0, 3'b101, 1'b1);
      step(2); chk("romwr_berr", o, 7'b0000011);
      step(2); chk("romwr_hold", o, 7'b0000011);
      release_bus(); step(2);

      // CTRL from user mode faults
      start(4'hF, 3'b001, 1'b0);
      step(2); chk("ctrl_user_berr", o, 7'b0000011);
      release_bus(); step(2);

      // CTRL from supervisor, 1 wait state
      start(4'hF, 3'b101, 1'b0);
      step(2); chk("ctrl_e1_en", o, 7'b0010001);
      step(1); chk("ctrl_e2_nodtack", o, 7'b0010001);
      step(1); chk("ctrl_e3_dtack", o, 7'b0010101);
      release_bus(); step(2);

      // Interrupt acknowledge faults even on a RAM address
      start(4'h2, 3'b111, 1'b0);
      step(2); chk("iack_berr", o, 7'b0000011);
      release_bus(); step(2);

      // IO timeout
      start(4'hE, 3'b101, 1'b0);
      step(2);  chk("io_e1_en", o, 7'b0001001);
      step(63); chk("io_e64_waiting", o, 7'b0001001);
      step(1);  chk("io_e65_berr", o, 7'b0000011);
      release_bus(); step(2);
      chk("io_to_idle", o, 7'b0000000);

      // IO completed by io_ready pulse at cycle 10
      start(4'hE, 3'b101, 1'b0);
      step(10); chk("io_rdy_e9", o, 7'b0001001);
      io_ready = 1'b1;
      step(1); chk("io_rdy_e10", o, 7'b0001001);
      io_ready = 1'b0;
      step(1); chk("io_rdy_e11_dtack", o, 7'b0001101);
      step(59); chk("io_rdy_e70_noberr", o, 7'b0001101);
      release_bus(); step(2);

      // Unmapped region, held for 20 cycles
      start(4'h9, 3'b101, 1'b0);
      step(2); chk("unmapped_berr", o, 7'b0000011);
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk($sformatf("unmapped_hold_%0d", i), o, 7'b0000011);
      end
      release_bus();
      step(1); chk("unmapped_release_e1", o, 7'b0000011);
      step(1); chk("unmapped_idle", o, 7'b0000000);

      // as without strobes waits; a late strobe starts the cycle
      addr_hi = 4'h3; fc = 3'b101; write = 1'b0; as = 1'b1; lds = 1'b0; uds = 1'b0;
      step(3); chk("nostrobe_idle", o, 7'b0000000);
      uds = 1'b1;
      step(1); chk("late_strobe_e0", o, 7'b0000000);
      addr_hi = 4'h9;
      step(1); chk("late_strobe_e1", o, 7'b0100001);
      step(1); chk("late_strobe_e2_frozen", o, 7'b0100101);
      release_bus(); step(2);

      // Abort during RAM_WS=3 wait
      start(4'h2, 3'b101, 1'b0);
      step(2); chk("abort_e1_en", o3, 7'b0100001);
      release_bus();
      step(1); chk("abort_e2", o3, 7'b0100001);
      step(1); chk("abort_e3_idle", o3, 7'b0000000);
      step(3); chk("abort_no_term", o3, 7'b0000000);

      // Asynchronous reset during ACK
      start(4'h2, 3'b101, 1'b0);
      step(3); chk("rst_pre_ack", o, 7'b0100101);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_clear", o, 7'b0000000);
      chk("rst_async_clear_ws3", o3, 7'b0000000);
      step(1);
      release_bus();
      rst_n = 1'b1;
      step(3); chk("rst_not_resumed", o, 7'b0000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
